player_input_capture: RTL and testbench
=======================================

# player_input_capture

Parametrised switch-entry capture for the Simon Says datapath, upstream of the sequence comparator. Synchronises and debounces N_SW player switches, and turns each flip-up/flip-down gesture into one entry. Multi-switch gestures are validated or merged according to a mode parameter. Accepted entries are buffered in a small FIFO drained by the comparator over a valid/ready handshake.

## Interface
- N_SW, 4, number of player switches / entry width
- DEBOUNCE_CYCLES, 16, cycles the synchronised vector must stay unchanged before it is accepted (≥2)
- DEPTH, 4, FIFO entries (≥2)
- ONEHOT_ONLY, 1, 1 = reject gestures with more than one switch set, 0 = accept the OR of all switches seen
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  capture enable (player turn active)
- flush  in  1  one-cycle pulse: empty FIFO, abort gesture
- sw  in  N_SW  raw asynchronous switches
- led  out  N_SW  pattern of gesture in progress
- entry_data  out  N_SW  FIFO head (first-word fall-through)
- entry_valid  out  1  FIFO non-empty
- entry_ready  in  1  comparator consumes head when valid & ready
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- invalid  out  1  one-cycle pulse: gesture rejected
- overflow  out  1  sticky: entry dropped on full FIFO; cleared by reset or flush

## Operation
- Reset: sync flops, candidate, counter, stable = 0; FSM IDLE; led=0, entry_data=0, entry_valid=0, count=0, invalid=0, overflow=0.
- Debounce: 2-flop synchroniser to sw_sync. If sw_sync≠cand, then cand←sw_sync and cnt←0. Else, if cnt=DEBOUNCE_CYCLES-1, then stable←cand. Else cnt++.
- FSM, states IDLE and HELD.
  - IDLE with enable & stable≠0: pat←stable, bad←(ONEHOT_ONLY & popcount(stable)>1), led←stable, go to HELD.
  - HELD with stable≠0 and stable≠pat: in ONEHOT_ONLY, bad←1 and pat is unchanged. Otherwise pat←pat|stable. In both cases led←pat|stable.
  - HELD with stable=0: commit, led←0, go to IDLE. Commit with bad set: pulse invalid, no push. Commit otherwise: push pat.
- Push on full without pop in the same cycle: entry dropped, overflow←1.
- Push and pop in the same cycle are both performed, including when full; count is unchanged.
- enable low: FSM forced to IDLE, led←0, partial gesture discarded with no invalid pulse. The FIFO keeps its contents and can still be drained.
- flush: FIFO emptied, overflow←0, FSM→IDLE, led←0. Any push or pop in that cycle is ignored. flush has priority over everything except reset.
- In IDLE with stable≠0 while enable rises: a gesture starts on the next cycle. A switch left up across a turn boundary therefore counts as a press.

## Timing
- A clean sw change reaches stable DEBOUNCE_CYCLES+3 edges after it is applied.
- Any pulse on sw shorter than DEBOUNCE_CYCLES cycles never changes stable.
- led updates 1 cycle after stable.
- Commit: stable→0 at edge k gives FIFO write at edge k+1; entry_valid and count update at edge k+1. The invalid pulse is high for the cycle after edge k+1.
- Pop: head advances at the edge where entry_valid & entry_ready. entry_data is combinational from the registered head and the storage array.
- Pointers wrap modulo DEPTH. The full/empty decision uses count, not pointer compare.

## Structure
- simon_pkg holds the N_SW default, the state enum (IDLE, HELD), and a popcount function shared with the comparator.
- Sub-module sw_debounce (N_SW, DEBOUNCE_CYCLES): sync, candidate, counter, stable output.
- FIFO storage, pointers and count stay inline in player_input_capture.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and DEPTH=4.
- Reset, then idle 10 cycles -> every output 0 and count=0.
- sw=0100 held 10 cycles, then 0000 held 10 cycles, entry_ready=0 -> led=0100 during hold, then entry_valid=1, entry_data=0100, count=1.
- 3-cycle glitch sw=0001, then 0000 -> stable never changes, led stays 0, nothing pushed.
- ONEHOT_ONLY=1: sw=0001, then 0011, then 0000 -> invalid pulses once, count unchanged. Same stimulus with ONEHOT_ONLY=0 -> entry 0011 pushed.
- Five gestures 0001, 0010, 0100, 1000, 0001 with entry_ready=0 -> count=4, overflow=1. Then ready=1 pops 0001, 0010, 0100, 1000 in order; flush then clears overflow.
- enable dropped while in HELD -> led=0, no push and no invalid pulse. FIFO full with push and pop in the same cycle -> count stays 4 and order is preserved.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared Simon Says types, defaults and helpers for the input capture and comparator blocks.
package simon_pkg;

  localparam int unsigned NSwDefault = 4;
  localparam int unsigned MaxSw      = 32;

  typedef enum logic [0:0] {
    IDLE,
    HELD
  } state_e;

  function automatic int unsigned popcount(input logic [MaxSw-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MaxSw; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a per-vector debounce: the synchronised switch vector must
// hold still for DEBOUNCE_CYCLES cycles before it is published on stable.
module sw_debounce
  import simon_pkg::*;
#(
  parameter int unsigned N_SW            = NSwDefault,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] stable
);

  localparam int unsigned    CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0] sync1_q, sync_q, cand_q, stable_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q <= sw;
      sync_q  <= sync1_q;
      if (sync_q != cand_q) begin
        cand_q <= sync_q;
        cnt_q  <= '0;
      end else if (cnt_q == CntMax) begin
        stable_q <= cand_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/player_input_capture.sv
// Turns debounced switch gestures into entries and queues them in a first-word fall-through
// FIFO for the sequence comparator.
module player_input_capture
  import simon_pkg::*;
#(
  parameter int unsigned N_SW            = NSwDefault,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DEPTH           = 4,
  parameter bit          ONEHOT_ONLY     = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [N_SW-1:0]            sw,
  output logic [N_SW-1:0]            led,
  output logic [N_SW-1:0]            entry_data,
  output logic                       entry_valid,
  input  logic                       entry_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       invalid,
  output logic                       overflow
);

  localparam int unsigned     CntW    = $clog2(DEPTH + 1);
  localparam int unsigned     PtrW    = $clog2(DEPTH);
  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  logic [N_SW-1:0] stable;

  sw_debounce #(
    .N_SW           (N_SW),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .stable(stable)
  );

  state_e          state_q, state_d;
  logic [N_SW-1:0] pat_q, pat_d, led_q, led_d;
  logic            bad_q, bad_d, invalid_q, invalid_d;
  logic            push, pop, full, wr_en;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    bad_d     = bad_q;
    led_d     = led_q;
    invalid_d = 1'b0;
    push      = 1'b0;
    if (flush || !enable) begin
      state_d = IDLE;
      led_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (stable != '0) begin
            state_d = HELD;
            pat_d   = stable;
            bad_d   = ONEHOT_ONLY && (popcount(MaxSw'(stable)) > 1);
            led_d   = stable;
          end
        end
        HELD: begin
          if (stable == '0) begin
            state_d   = IDLE;
            led_d     = '0;
            invalid_d = bad_q;
            push      = !bad_q;
          end else if (stable != pat_q) begin
            if (ONEHOT_ONLY) bad_d = 1'b1;
            else             pat_d = pat_q | stable;
            led_d = pat_q | stable;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      bad_q     <= 1'b0;
      led_q     <= '0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      bad_q     <= bad_d;
      led_q     <= led_d;
      invalid_q <= invalid_d;
    end
  end

  logic [N_SW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [CntW-1:0] count_q;
  logic            overflow_q;

  assign full        = (count_q == Full);
  assign entry_valid = (count_q != '0);
  assign pop         = entry_valid && entry_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en       = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= (wr_q == PtrLast) ? '0 : wr_q + 1'b1;
      if (pop)   rd_q <= (rd_q == PtrLast) ? '0 : rd_q + 1'b1;
      if (wr_en && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !wr_en) count_q <= count_q - 1'b1;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_en) mem_q[wr_q] <= pat_q;
  end

  assign led        = led_q;
  assign entry_data = entry_valid ? mem_q[rd_q] : '0;
  assign count      = count_q;
  assign invalid    = invalid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_player_input_capture.sv
// Drives one-hot-only and merging instances side by side against a gesture-level reference model.
module tb_player_input_capture;

  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, enable, flush, entry_ready;
  logic [3:0] sw;

  logic [3:0] led_w [2];
  logic [3:0] data_w [2];
  logic [2:0] count_w [2];
  logic       valid_w [2];
  logic       inv_w [2];
  logic       ovf_w [2];

  always #5 clk = ~clk;

  player_input_capture #(
    .N_SW(4), .DEBOUNCE_CYCLES(D), .DEPTH(DEPTH), .ONEHOT_ONLY(1'b1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .sw(sw),
    .led(led_w[1]), .entry_data(data_w[1]), .entry_valid(valid_w[1]),
    .entry_ready(entry_ready), .count(count_w[1]), .invalid(inv_w[1]), .overflow(ovf_w[1])
  );

  player_input_capture #(
    .N_SW(4), .DEBOUNCE_CYCLES(D), .DEPTH(DEPTH), .ONEHOT_ONLY(1'b0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .sw(sw),
    .led(led_w[0]), .entry_data(data_w[0]), .entry_valid(valid_w[0]),
    .entry_ready(entry_ready), .count(count_w[0]), .invalid(inv_w[0]), .overflow(ovf_w[0])
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: sw sample history, gesture state per instance, FIFO as a shifted array.
  logic [3:0] samp [D+3];
  logic [3:0] m_stable;
  logic       m_held [2];
  logic [3:0] m_pat [2];
  logic       m_bad [2];
  logic [3:0] m_led [2];
  logic       m_inv [2];
  logic       m_ovf [2];
  logic [3:0] m_q [2][8];
  int         m_cnt [2];
  int         inv_pulses [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic       pop, push, same;
    logic [3:0] pdata;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      push     = 1'b0;
      pdata    = m_pat[m];
      m_inv[m] = 1'b0;
      if (reset) begin
        m_held[m] = 1'b0; m_pat[m] = '0; m_bad[m] = 1'b0; m_led[m] = '0;
        m_cnt[m]  = 0;    m_ovf[m] = 1'b0;
      end else if (flush) begin
        m_cnt[m] = 0; m_ovf[m] = 1'b0; m_held[m] = 1'b0; m_led[m] = '0;
      end else begin
        pop = (m_cnt[m] > 0) && entry_ready;
        if (!enable) begin
          m_held[m] = 1'b0;
          m_led[m]  = '0;
        end else if (!m_held[m]) begin
          if (m_stable != 0) begin
            m_held[m] = 1'b1;
            m_pat[m]  = m_stable;
            m_bad[m]  = (m == 1) && ($countones(m_stable) > 1);
            m_led[m]  = m_stable;
          end
        end else if (m_stable == 0) begin
          m_held[m] = 1'b0;
          m_led[m]  = '0;
          if (m_bad[m]) m_inv[m] = 1'b1;
          else          push = 1'b1;
        end else if (m_stable != m_pat[m]) begin
          m_led[m] = m_pat[m] | m_stable;
          if (m == 1) m_bad[m] = 1'b1;
          else        m_pat[m] = m_pat[m] | m_stable;
        end
        if (pop) begin
          for (int i = 0; i < 7; i++) m_q[m][i] = m_q[m][i+1];
          m_cnt[m]--;
        end
        if (push) begin
          if (m_cnt[m] < DEPTH) begin
            m_q[m][m_cnt[m]] = pdata;
            m_cnt[m]++;
          end else begin
            m_ovf[m] = 1'b1;
          end
        end
      end
    end
    // stable takes a value once D+1 consecutive synchronised samples agree on it
    for (int i = D + 2; i > 0; i--) samp[i] = samp[i-1];
    samp[0] = reset ? 4'b0 : sw;
    if (reset) begin
      for (int i = 0; i < D + 3; i++) samp[i] = '0;
      m_stable = '0;
    end else begin
      same = 1'b1;
      for (int i = 3; i < D + 3; i++) if (samp[i] != samp[2]) same = 1'b0;
      if (same) m_stable = samp[2];
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      if (inv_w[m]) inv_pulses[m]++;
      check($sformatf("led%0d", m), 8'(led_w[m]), 8'(m_led[m]));
      check($sformatf("valid%0d", m), 8'(valid_w[m]), 8'(m_cnt[m] > 0));
      check($sformatf("data%0d", m), 8'(data_w[m]), (m_cnt[m] > 0) ? 8'(m_q[m][0]) : 8'h00);
      check($sformatf("count%0d", m), 8'(count_w[m]), 8'(m_cnt[m]));
      check($sformatf("invalid%0d", m), 8'(inv_w[m]), 8'(m_inv[m]));
      check($sformatf("overflow%0d", m), 8'(ovf_w[m]), 8'(m_ovf[m]));
    end
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic gesture(input logic [3:0] g);
    sw = g;
    hold(10);
    sw = 4'b0;
    hold(10);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
  endtask

  logic [3:0] exp_order [4];
  logic       found;

  initial begin
    reset = 1'b1; enable = 1'b0; flush = 1'b0; entry_ready = 1'b0; sw = '0;
    m_stable = '0;
    for (int i = 0; i < D + 3; i++) samp[i] = '0;
    for (int m = 0; m < 2; m++) begin
      m_held[m] = 1'b0; m_pat[m] = '0; m_bad[m] = 1'b0; m_led[m] = '0; m_inv[m] = 1'b0;
      m_ovf[m]  = 1'b0; m_cnt[m] = 0;  inv_pulses[m] = 0;
      for (int i = 0; i < 8; i++) m_q[m][i] = '0;
    end
    hold(3);
    reset = 1'b0;
    hold(10);
    check("reset_count", 8'(count_w[1]), 8'h00);
    check("reset_led", 8'(led_w[1]), 8'h00);
    check("reset_overflow", 8'(ovf_w[1]), 8'h00);

    enable = 1'b1;
    sw = 4'b0100;
    hold(10);
    check("hold_led1", 8'(led_w[1]), 8'h04);
    check("hold_led0", 8'(led_w[0]), 8'h04);
    sw = 4'b0000;
    hold(10);
    check("single_valid", 8'(valid_w[1]), 8'h01);
    check("single_data", 8'(data_w[1]), 8'h04);
    check("single_count", 8'(count_w[1]), 8'h01);

    sw = 4'b0001;
    hold(3);
    sw = 4'b0000;
    hold(10);
    check("glitch_count", 8'(count_w[1]), 8'h01);

    inv_pulses[0] = 0; inv_pulses[1] = 0;
    sw = 4'b0001; hold(10);
    sw = 4'b0011; hold(10);
    sw = 4'b0000; hold(10);
    check("multi_invalid1", 8'(inv_pulses[1]), 8'h01);
    check("multi_count1", 8'(count_w[1]), 8'h01);
    check("multi_invalid0", 8'(inv_pulses[0]), 8'h00);
    check("multi_count0", 8'(count_w[0]), 8'h02);

    pulse_flush();
    check("flush_count", 8'(count_w[0]), 8'h00);

    gesture(4'b0001); gesture(4'b0010); gesture(4'b0100); gesture(4'b1000); gesture(4'b0001);
    check("ovf_count", 8'(count_w[1]), 8'h04);
    check("ovf_flag", 8'(ovf_w[1]), 8'h01);
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100; exp_order[3] = 4'b1000;
    entry_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), 8'(data_w[1]), 8'(exp_order[i]));
      step();
    end
    entry_ready = 1'b0;
    check("drained_count", 8'(count_w[1]), 8'h00);
    check("ovf_sticky", 8'(ovf_w[1]), 8'h01);
    pulse_flush();
    check("ovf_cleared", 8'(ovf_w[1]), 8'h00);

    inv_pulses[1] = 0;
    sw = 4'b0010; hold(10);
    check("abort_led_before", 8'(led_w[1]), 8'h02);
    enable = 1'b0;
    step();
    check("abort_led", 8'(led_w[1]), 8'h00);
    sw = 4'b0000; hold(10);
    enable = 1'b1; hold(3);
    check("abort_count", 8'(count_w[1]), 8'h00);
    check("abort_invalid", 8'(inv_pulses[1]), 8'h00);

    gesture(4'b0001); gesture(4'b0010); gesture(4'b0100); gesture(4'b1000);
    sw = 4'b0001; hold(10);
    sw = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_held[1] && m_stable == 0) begin
        entry_ready = 1'b1;
        step();
        entry_ready = 1'b0;
        found = 1'b1;
      end else begin
        step();
      end
    end
    check("pushpop_commit_seen", 8'(found), 8'h01);
    check("pushpop_count", 8'(count_w[1]), 8'h04);
    check("pushpop_overflow", 8'(ovf_w[1]), 8'h00);
    exp_order[0] = 4'b0010; exp_order[1] = 4'b0100; exp_order[2] = 4'b1000; exp_order[3] = 4'b0001;
    hold(3);
    entry_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pushpop_order%0d", i), 8'(data_w[1]), 8'(exp_order[i]));
      step();
    end
    entry_ready = 1'b0;
    pulse_flush();

    for (int s = 0; s < 300; s++) begin
      case ($urandom_range(0, 3))
        0:       sw = 4'b0;
        1:       sw = 4'(1 << $urandom_range(0, 3));
        default: sw = 4'($urandom_range(0, 15));
      endcase
      entry_ready = 1'($urandom_range(0, 1));
      enable      = ($urandom_range(0, 15) != 0);
      flush       = ($urandom_range(0, 31) == 0);
      step();
      flush = 1'b0;
      hold($urandom_range(0, 9));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
